button_debounce_array: RTL



---
 rtl/btn_pkg.sv | 24 ++
 rtl/debounce_channel.sv | 110 +++++++++++
 rtl/button_debounce_array.sv | 64 ++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding and
// the elaboration-time counter width check.
package btn_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDebOn  = 2'd1,
        StOn     = 2'd2,
        StDebOff = 2'd3
    } btn_state_e;

    // True when a CNT_W-bit counter can reach every tick limit.
    function automatic bit cnt_w_fits(input int unsigned cnt_w, input int unsigned stable_ms,
                                      input int unsigned hold_ms, input int unsigned repeat_ms);
        longint unsigned lim;
        longint unsigned cap;
        lim = stable_ms;
        if (hold_ms > lim)   lim = hold_ms;
        if (repeat_ms > lim) lim = repeat_ms;
        cap = (longint'(1) << cnt_w) - 1;
        return (cnt_w >= 1) && (cnt_w <= 32) && (lim <= cap);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, debounce/auto-repeat FSM and its
// tick counter. Advances only on the shared prescaler tick.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_MS = 20,
    parameter int unsigned HOLD_MS   = 200,
    parameter int unsigned REPEAT_MS = 100,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    input  logic tick,
    output logic level,
    output logic press,
    output logic released
);

    localparam logic [CNT_W:0] STABLE_LIM = (CNT_W+1)'(STABLE_MS);
    localparam logic [CNT_W:0] HOLD_LIM   = (CNT_W+1)'(HOLD_MS);
    localparam logic [CNT_W:0] REPEAT_LIM = (CNT_W+1)'(REPEAT_MS);

    logic             sync1;
    logic             s_in;
    btn_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             rep_phase;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   rep_lim;

    // One bit wider so the compare against a limit equal to 2^CNT_W-1 cannot wrap.
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
    assign rep_lim = rep_phase ? REPEAT_LIM : HOLD_LIM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            s_in      <= 1'b0;
            state     <= StIdle;
            cnt       <= '0;
            rep_phase <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            released  <= 1'b0;
        end else begin
            sync1    <= btn_in;
            s_in     <= sync1;
            press    <= 1'b0;
            released <= 1'b0;
            case (state)
                StIdle: begin
                    if (s_in) begin
                        state <= StDebOn;
                        cnt   <= '0;
                    end
                end
                StDebOn: begin
                    if (!s_in) begin
                        state <= StIdle;
                    end else if (tick) begin
                        if (cnt_inc == STABLE_LIM) begin
                            state     <= StOn;
                            cnt       <= '0;
                            rep_phase <= 1'b0;
                            level     <= 1'b1;
                            press     <= 1'b1;
                        end else begin
                            cnt <= cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                StOn: begin
                    if (!s_in) begin
                        state     <= StDebOff;
                        cnt       <= '0;
                        rep_phase <= 1'b0;
                    end else if (repeat_en && tick) begin
                        if (cnt_inc == rep_lim) begin
                            press     <= 1'b1;
                            cnt       <= '0;
                            rep_phase <= 1'b1;
                        end else begin
                            cnt <= cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                StDebOff: begin
                    if (s_in) begin
                        state     <= StOn;
                        cnt       <= '0;
                        rep_phase <= 1'b0;
                    end else if (tick) begin
                        if (cnt_inc == STABLE_LIM) begin
                            state    <= StIdle;
                            cnt      <= '0;
                            level    <= 1'b0;
                            released <= 1'b1;
                        end else begin
                            cnt <= cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/button_debounce_array.sv
// N-channel push-button conditioner: shared millisecond prescaler feeding one
// debounce_channel per button.
module button_debounce_array
    import btn_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned TICK_CYCLES = 50000,
    parameter int unsigned STABLE_MS   = 20,
    parameter int unsigned HOLD_MS     = 200,
    parameter int unsigned REPEAT_MS   = 100,
    parameter int unsigned CNT_W       = 8
) (
    input  logic            qzt_clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] released,
    output logic            tick
);

    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

    if (!cnt_w_fits(CNT_W, STABLE_MS, HOLD_MS, REPEAT_MS)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for max(STABLE_MS, HOLD_MS, REPEAT_MS)");
    end

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;

    assign presc_next = (presc == PRESC_MAX) ? '0 : presc + PW'(1);

    // tick is registered so it is high exactly while presc == TICK_CYCLES-1.
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= presc_next;
            tick  <= (presc_next == PRESC_MAX);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_MS (STABLE_MS),
            .HOLD_MS   (HOLD_MS),
            .REPEAT_MS (REPEAT_MS),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk       (qzt_clk),
            .rst       (reset),
            .btn_in    (btn_in[i]),
            .repeat_en (repeat_en[i]),
            .tick      (tick),
            .level     (level[i]),
            .press     (press[i]),
            .released  (released[i])
        );
    end

endmodule
